// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a valid/ready load port and a shift-enable stall.
// Back-to-back words reload on the last bit so the serial stream has no idle gap.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_load_valid,
    output logic             o_load_ready,
    input  logic             i_shift_en,
    output logic             o_out,
    output logic             o_out_valid,
    output logic             o_last,
    output logic             o_busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_shifted;
    logic             last;
    logic             accept;

    assign last         = (state_q == S_SHIFT) && (cnt_q == LAST_CNT);
    assign o_load_ready = ~i_rst & ((state_q == S_IDLE) | (last & i_shift_en));
    assign accept       = i_load_valid & o_load_ready;

    assign o_busy      = (state_q == S_SHIFT);
    assign o_out_valid = o_busy;
    assign o_last      = last;
    assign o_out       = o_busy & (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);

    // Zero fill from the end opposite the output bit.
    assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, sreg_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sreg_d  = i_data;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (i_shift_en) begin
                    if (!last) begin
                        sreg_d = sreg_shifted;
                        cnt_d  = cnt_q + 1'b1;
                    end else if (accept) begin
                        sreg_d = i_data;
                        cnt_d  = '0;
                    end else begin
                        sreg_d  = '0;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                sreg_d  = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: directed scenarios plus a randomized run
// checked against a bit-queue reference model; a second instance covers LSB-first order.
module tb_piso_serializer;

    logic       clk;
    logic       rst;
    logic       se;
    logic [7:0] data0, data1;
    logic       lv0, lv1;
    logic       rdy0, out0, ov0, last0, busy0;
    logic       rdy1, out1, ov1, last1, busy1;
    logic [7:0] sipo;

    int n_checks = 0;
    int n_fail   = 0;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_data(data0),
        .i_load_valid(lv0), .o_load_ready(rdy0),
        .i_shift_en(se), .o_out(out0), .o_out_valid(ov0),
        .o_last(last0), .o_busy(busy0)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_data(data1),
        .i_load_valid(lv1), .o_load_ready(rdy1),
        .i_shift_en(se), .o_out(out1), .o_out_valid(ov1),
        .o_last(last1), .o_busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the downstream SIPO: left-shift fill on enable.
    always @(posedge clk) begin
        if (se) sipo <= {sipo[6:0], out0};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; se = 1'b1; lv0 = 1'b0; lv1 = 1'b0;
        data0 = '0; data1 = '0;
        tick(); tick();
        n_checks++;
        if ({out0, ov0, last0, busy0, rdy0} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_dut0: got %b want 00000",
                     {out0, ov0, last0, busy0, rdy0});
        end
        n_checks++;
        if ({out1, ov1, last1, busy1, rdy1} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_dut1: got %b want 00000",
                     {out1, ov1, last1, busy1, rdy1});
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (rdy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", rdy0);
        end
    endtask

    task automatic test_single();
        logic [7:0] w = 8'hA5;
        lv0 = 1'b1; data0 = w;
        tick();
        lv0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({out0, ov0, last0} !== {w[7-i], 1'b1, (i == 7)}) begin
                n_fail++;
                $display("FAIL single_bit%0d: got %b want %b", i,
                         {out0, ov0, last0}, {w[7-i], 1'b1, (i == 7)});
            end
            tick();
        end
        n_checks++;
        if ({ov0, rdy0, busy0} !== 3'b010) begin
            n_fail++;
            $display("FAIL single_done: got %b want 010", {ov0, rdy0, busy0});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp = 16'hA53C;
        lv0 = 1'b1; data0 = 8'hA5;
        tick();
        data0 = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if ({out0, ov0, busy0, rdy0} !==
                {exp[15-i], 1'b1, 1'b1, (i == 7 || i == 15)}) begin
                n_fail++;
                $display("FAIL b2b_bit%0d: got %b want %b", i,
                         {out0, ov0, busy0, rdy0},
                         {exp[15-i], 1'b1, 1'b1, (i == 7 || i == 15)});
            end
            tick();
            if (i == 7) lv0 = 1'b0;
        end
        n_checks++;
        if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done: busy got %b want 0", busy0);
        end
    endtask

    task automatic test_stall();
        logic [7:0] w = 8'hF0;
        lv0 = 1'b1; data0 = w;
        tick();
        lv0 = 1'b0;
        tick();
        se = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            n_checks++;
            if ({out0, ov0, last0, rdy0} !== 4'b1100) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got %b want 1100", s,
                         {out0, ov0, last0, rdy0});
            end
            tick();
        end
        se = 1'b1;
        for (int i = 1; i < 8; i++) begin
            n_checks++;
            if ({out0, ov0, last0} !== {w[7-i], 1'b1, (i == 7)}) begin
                n_fail++;
                $display("FAIL stall_resume_bit%0d: got %b want %b", i,
                         {out0, ov0, last0}, {w[7-i], 1'b1, (i == 7)});
            end
            tick();
        end
        n_checks++;
        if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_done: busy got %b want 0", busy0);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] w = 8'h81;
        lv0 = 1'b1; data0 = 8'hC3;
        tick();
        lv0 = 1'b0;
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out0, ov0, last0, busy0, rdy0} !== 5'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %b want 00000",
                     {out0, ov0, last0, busy0, rdy0});
        end
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({busy0, rdy0} !== 2'b01) begin
            n_fail++;
            $display("FAIL midreset_release: got %b want 01", {busy0, rdy0});
        end
        lv0 = 1'b1; data0 = w;
        tick();
        lv0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({out0, ov0, last0} !== {w[7-i], 1'b1, (i == 7)}) begin
                n_fail++;
                $display("FAIL midreset_bit%0d: got %b want %b", i,
                         {out0, ov0, last0}, {w[7-i], 1'b1, (i == 7)});
            end
            tick();
        end
    endtask

    task automatic test_loopback();
        logic [7:0] words [2] = '{8'h5A, 8'hFF};
        for (int k = 0; k < 2; k++) begin
            lv0 = 1'b1; data0 = words[k];
            tick();
            lv0 = 1'b0;
            repeat (8) tick();
            n_checks++;
            if (sipo !== words[k]) begin
                n_fail++;
                $display("FAIL loopback_%0d: got %h want %h", k, sipo, words[k]);
            end
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] w;
        for (int k = 0; k < 3; k++) begin
            w = (k == 0) ? 8'h01 : 8'($urandom);
            lv1 = 1'b1; data1 = w;
            tick();
            lv1 = 1'b0;
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if ({out1, ov1, last1} !== {w[i], 1'b1, (i == 7)}) begin
                    n_fail++;
                    $display("FAIL lsb_w%0d_bit%0d: got %b want %b", k, i,
                             {out1, ov1, last1}, {w[i], 1'b1, (i == 7)});
                end
                tick();
            end
        end
    endtask

    task automatic test_random();
        bit         q[$];
        logic       e_busy, e_last, e_out, e_rdy, acc;
        logic [7:0] d;
        for (int c = 0; c < 400; c++) begin
            se    = ($urandom_range(0, 3) != 0);
            lv0   = 1'($urandom_range(0, 1));
            data0 = 8'($urandom);
            #1;
            e_busy = (q.size() != 0);
            e_last = (q.size() == 1);
            e_out  = e_busy ? q[0] : 1'b0;
            e_rdy  = !e_busy || (e_last && se);
            n_checks++;
            if ({out0, ov0, last0, busy0, rdy0} !==
                {e_out, e_busy, e_last, e_busy, e_rdy}) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got %b want %b", c,
                         {out0, ov0, last0, busy0, rdy0},
                         {e_out, e_busy, e_last, e_busy, e_rdy});
            end
            acc = lv0 && e_rdy;
            d   = data0;
            @(posedge clk);
            if (e_busy && se) void'(q.pop_front());
            if (acc) begin
                for (int k = 7; k >= 0; k--) q.push_back(d[k]);
            end
            #1;
        end
        lv0 = 1'b0; se = 1'b1;
        repeat (10) tick();
        n_checks++;
        if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL random_drain: busy got %b want 0", busy0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_loopback();
        test_lsb_first();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
